// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, packet-atomic arbiter feeding one FIFO writer.
// Optional stall-abort counter enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic [DATA_WIDTH-1:0]         fifo_d_o,
    output logic                          fifo_enq_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_alm_full_i,
    output logic                          timeout_o
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, OWN} state_t;
    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt, last_grant, last_nxt, pick;
    logic          own, xfer;
    assign own         = (state == OWN);
    assign grant_o     = own ? (NUM_REQ'(1) << owner) : '0;
    assign busy_o      = own;
    assign req_ready_o = grant_o & {NUM_REQ{!fifo_full_i}};
    assign xfer        = own && req_valid_i[owner] && !fifo_full_i;
    assign fifo_enq_o  = xfer;
    assign fifo_d_o    = own ? req_data_i[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    // Scan downward so the nearest requester after last_grant is the final assignment.
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ; i >= 1; i--)
            if (req_valid_i[IW'((int'(last_grant) + i) % NUM_REQ)])
                pick = IW'((int'(last_grant) + i) % NUM_REQ);
    end
`ifdef FIFO_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;
    assign timeout_o = own && !req_valid_i[owner] && (int'(stall_cnt) + 1 >= TIMEOUT);
    always_ff @(posedge clk) begin
        if (!rst_n_i || !own || xfer || timeout_o)
            stall_cnt <= '0;
        else if (!req_valid_i[owner])
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign timeout_o = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_grant;
        if (!own) begin
            if (|req_valid_i && !fifo_alm_full_i) begin
                state_nxt = OWN;
                owner_nxt = pick;
            end
        end else if ((xfer && req_last_i[owner]) || timeout_o) begin
            state_nxt = IDLE;
            last_nxt  = owner;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_nxt;
        end
    end
endmodule
